rr_chooser_arbiter: RTL and testbench

- Round-robin arbiter that shares one N-way select resource (one-hot chooser/channel select) between N requesters.
- Issues a one-hot grant, holds it until the owner releases, then rotates priority past the last owner.
- Sits between requester logic (buttons, display/channel clients) and the shared select datapath.
- Replaces free-running shift selection with demand-driven, fair selection.

---
 rtl/rr_chooser_arbiter_pkg.sv | 18 +
 rtl/rr_chooser_arbiter_if.sv | 27 ++
 rtl/rr_chooser_arbiter_rr_pick.sv | 40 ++++
 rtl/rr_chooser_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_chooser_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/rr_chooser_arbiter_pkg.sv
// Shared types and helpers for the round-robin chooser arbiter.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int ARB_N_DEF        = 3;
  localparam int ARB_HOLD_MAX_DEF = 15;

  // Next index in the circular search order.
  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_chooser_arbiter_if.sv
// Requester-side bundle of the chooser arbiter.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
interface rr_chooser_arbiter_if #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
);
  // REQ[k] is a level held by requester k until it has been granted and served.
  // GNT is one-hot while GNT_VALID is high. DONE is a one-cycle release strobe
  // from the owner and is only honoured while a grant is held. TIMEOUT pulses
  // for one cycle when a grant is taken away by force.
  logic [N-1:0]  REQ;
  logic          DONE;
  logic [N-1:0]  GNT;
  logic [IW-1:0] GNT_IDX;
  logic          GNT_VALID;
  logic          TIMEOUT;

  modport master (
    output REQ, DONE,
    input  GNT, GNT_IDX, GNT_VALID, TIMEOUT
  );

  modport slave (
    input  REQ, DONE,
    output GNT, GNT_IDX, GNT_VALID, TIMEOUT
  );
endinterface

// File: rtl/rr_chooser_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate by ptr, take lowest set bit, unrotate.
// Optional hold timeout (ARB_TIMEOUT_EN) does not affect this block.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] rot;
  logic [IW:0]  k;
  logic [IW:0]  ridx;
  logic [IW:0]  sum;

  always_comb begin
    rot  = '0;
    k    = '0;
    ridx = '0;
    sum  = '0;
    // rot[j] is the request at distance j from ptr in search order.
    for (int j = 0; j < N; j++) begin
      k = (IW+1)'(j) + {1'b0, ptr};
      if (k >= (IW+1)'(N)) k = k - (IW+1)'(N);
      rot[j] = req[k[IW-1:0]];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) ridx = (IW+1)'(i);
    end
    sum = ridx + {1'b0, ptr};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    any = |req;
    idx = any ? sum[IW-1:0] : '0;
    win = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_chooser_arbiter.sv
// Round-robin arbiter sharing one N-way select between N requesters.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX cycles when others wait.
module rr_chooser_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int IW       = $clog2(N),
  parameter int HOLD_MAX = ARB_HOLD_MAX_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  rr_chooser_arbiter_if.slave  bus,
  output state_t               DBG_STATE,
  output logic [IW-1:0]        DBG_PTR
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("rr_chooser_arbiter: N must be in 2..8");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("rr_chooser_arbiter: HOLD_MAX must be >= 1");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          normal_rel;
  logic          forced_rel;

  logic [N-1:0]  pick_win;
  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (bus.REQ),
    .ptr (ptr_q),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    normal_rel = bus.DONE | ~bus.REQ[idx_q];
`ifdef ARB_TIMEOUT_EN
    hold_d     = hold_q;
    // Only force a release when someone else is actually waiting.
    forced_rel = (hold_q == HW'(HOLD_MAX)) && ((bus.REQ & ~gnt_q) != '0);
`else
    forced_rel = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_win;
          idx_d   = pick_idx;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (normal_rel || forced_rel) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = IW'(mod_inc(int'(idx_q), N));
          timeout_d = forced_rel & ~normal_rel;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q != HW'(HOLD_MAX)) begin
          hold_d = hold_q + HW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  assign bus.GNT       = gnt_q;
  assign bus.GNT_IDX   = idx_q;
  assign bus.GNT_VALID = valid_q;
  assign bus.TIMEOUT   = timeout_q;
  assign DBG_STATE     = state_q;
  assign DBG_PTR       = ptr_q;

endmodule

// File: tb/tb_rr_chooser_arbiter.sv
// Bench for rr_chooser_arbiter: directed steps plus random traffic against a reference model.
// Timeout expectations follow ARB_TIMEOUT_EN when it is defined for the build.
module tb_rr_chooser_arbiter;
  import arb_pkg::*;

  localparam int N        = 3;
  localparam int IW       = $clog2(N);
  localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_chooser_arbiter_if #(.N(N)) bus ();
  state_t        dbg_state;
  logic [IW-1:0] dbg_ptr;

  rr_chooser_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .DBG_STATE (dbg_state),
    .DBG_PTR   (dbg_ptr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int to_cnt   = 0;

  // reference model: who owns the resource, priority pointer, hold time
  bit m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rel_n, forced, others;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      for (int j = 0; j < N; j++) begin
        int k;
        k = (m_ptr + j) % N;
        if (!m_busy && bus.REQ[k]) begin
          m_busy = 1; m_owner = k; m_hold = 0;
        end
      end
    end else begin
      others = 0;
      for (int j = 0; j < N; j++)
        if (j != m_owner && bus.REQ[j]) others = 1;
      rel_n  = bus.DONE || !bus.REQ[m_owner];
      forced = TO_EN && (m_hold == HOLD_MAX) && others;
      m_to   = forced && !rel_n;
      if (rel_n || forced) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (m_hold < HOLD_MAX) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    chk("gnt",       32'(bus.GNT),       32'(eg));
    chk("gnt_idx",   32'(bus.GNT_IDX),   m_busy ? 32'(m_owner) : 32'd0);
    chk("gnt_valid", 32'(bus.GNT_VALID), 32'(m_busy));
    chk("timeout",   32'(bus.TIMEOUT),   32'(m_to));
    chk("ptr",       32'(dbg_ptr),       32'(m_ptr));
    chk("state",     32'(dbg_state == GRANT), 32'(m_busy));
    chk("onehot0",   32'($onehot0(bus.GNT)), 32'd1);
  endtask

  // driver: inputs change #1 after an edge, outputs are checked #1 after the next
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (bus.TIMEOUT) to_cnt++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.REQ = '0; bus.DONE = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] order_exp [7];
    order_exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    bus.REQ = '0; bus.DONE = 1'b0;

    // idle with no requests
    do_reset();
    repeat (5) step();

    // all requesting, DONE one cycle after each grant: order rotates and wraps
    bus.REQ = 3'b111;
    for (int i = 0; i < 7; i++) begin
      bus.DONE = (i % 2 == 1);
      step();
      chk("order", 32'(bus.GNT), 32'(order_exp[i]));
    end
    bus.DONE = 1'b0;

    // single top requester, released by dropping its request
    do_reset();
    bus.REQ = 3'b100;
    step();
    chk("gnt_req2", 32'(bus.GNT), 32'b100);
    chk("idx_req2", 32'(bus.GNT_IDX), 32'd2);
    bus.REQ = 3'b000;
    step();
    chk("drop_gnt", 32'(bus.GNT), 32'd0);
    chk("drop_ptr", 32'(dbg_ptr), 32'd0);

    // new request mid-grant is ignored until the owner finishes
    do_reset();
    bus.REQ = 3'b001;
    step();
    bus.REQ = 3'b011;
    repeat (3) begin
      step();
      chk("hold_owner", 32'(bus.GNT), 32'b001);
    end
    bus.DONE = 1'b1;
    step();
    bus.DONE = 1'b0;
    step();
    chk("after_idle", 32'(bus.GNT), 32'b010);

    // reset in the middle of a grant
    rst = 1'b1;
    step();
    chk("rst_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("rst_to",  32'(bus.TIMEOUT), 32'd0);
    rst = 1'b0;
    bus.REQ = 3'b011;
    step();
    chk("post_rst", 32'(bus.GNT), 32'b001);

    // owner never releases while another requester waits
    do_reset();
    to_cnt = 0;
    bus.REQ = 3'b011;
    repeat (8) step();
    chk("to_pulses_wait", 32'(to_cnt), TO_EN ? 32'd1 : 32'd0);
    chk("to_gnt_wait",    32'(bus.GNT), TO_EN ? 32'b010 : 32'b001);

    // owner alone never times out
    do_reset();
    to_cnt = 0;
    bus.REQ = 3'b001;
    repeat (20) step();
    chk("to_pulses_alone", 32'(to_cnt), 32'd0);
    chk("to_gnt_alone",    32'(bus.GNT), 32'b001);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      bus.REQ  = N'($urandom_range(0, (1 << N) - 1));
      bus.DONE = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
